// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one word per valid/ready handshake becomes an
// asynchronous frame on tx_o: start bit, DATA_BITS data bits LSB-first,
// optional parity bit, then STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT
// cycles. tx_o is registered and idles high.
//
// Handshake: a word transfers at a posedge where valid_i && ready_o. ready_o
// is high only in IDLE. valid_i is ignored while busy, and nothing is queued.
module uart_tx_serializer #(
    parameter int    CLKS_PER_BIT = 868,
    parameter int    DATA_BITS    = 8,
    parameter string PARITY       = "none",
    parameter int    STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // Reject unsupported frame formats when the design is elaborated
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..9");
    end
    if (PARITY != "none" && PARITY != "even" && PARITY != "odd") begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be none, even or odd");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam int CW      = $clog2(CLKS_PER_BIT);
    localparam int BW      = $clog2(DATA_BITS);
    localparam bit PAR_EN  = (PARITY != "none");
    localparam bit PAR_ODD = (PARITY == "odd");

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 tx_q;
    logic                 done_q;
    logic                 baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign ready_o   = (state == ST_IDLE);
    assign busy_o    = (state != ST_IDLE);
    assign tx_o      = tx_q;
    assign done_o    = done_q;

    // Baud counter: held at zero while idle, wraps at the end of every bit
    always_ff @(posedge clk_i) begin
        if (rst_i || state == ST_IDLE) begin
            baud_cnt <= '0;
        end else if (baud_last) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Frame sequencer: state, line level, shift register and bit counting.
    // bit_cnt indexes data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (valid_i) begin
                        state   <= ST_START;
                        tx_q    <= 1'b0;
                        shift   <= data_i;
                        bit_cnt <= '0;
                        // Parity is taken from the word as it is latched
                        par_bit <= PAR_ODD ? ~(^data_i) : (^data_i);
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        state   <= ST_DATA;
                        tx_q    <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PAR_EN) begin
                                state <= ST_PARITY;
                                tx_q  <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            tx_q    <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_last) begin
                        state   <= ST_STOP;
                        tx_q    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= ST_IDLE;
                            done_q  <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_q    <= 1'b1;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Three DUT instances cover 8N1, 8E1 and 5O2 at
// CLKS_PER_BIT 4/4/2. For each instance:
//   - The driver pushes each accepted word onto exp_q.
//   - A monitor watches the outputs every cycle. When a frame starts, it pops
//     the word and compares the line against a frame built from the UART
//     framing rules.
module tb_uart_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int cfg, input int cyc,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cfg=%0d cyc=%0d got=%0h want=%0h", nm, cfg, cyc, got, want);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int    C  = (g == 2) ? 2 : 4;
        localparam int    DB = (g == 2) ? 5 : 8;
        localparam int    PM = g;  // 0 none, 1 even, 2 odd
        localparam string PS = (g == 1) ? "even" : ((g == 2) ? "odd" : "none");
        localparam int    SB = (g == 2) ? 2 : 1;
        localparam int    NB = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
        localparam int    L  = C * NB;

        logic          rst   = 1'b1;
        logic          valid = 1'b0;
        logic [DB-1:0] data  = '0;
        logic          ready, tx, busy, done;
        logic          rst_at_edge = 1'b1;
        logic          fin_flag    = 1'b0;
        logic          in_frame    = 1'b0;
        logic [DB-1:0] exp_q[$];

        uart_tx_serializer #(
            .CLKS_PER_BIT(C),
            .DATA_BITS   (DB),
            .PARITY      (PS),
            .STOP_BITS   (SB)
        ) dut (
            .clk_i  (clk),
            .rst_i  (rst),
            .data_i (data),
            .valid_i(valid),
            .ready_o(ready),
            .tx_o   (tx),
            .busy_o (busy),
            .done_o (done)
        );

        // Remember whether reset was applied at the latest rising edge
        always @(posedge clk) rst_at_edge <= rst;

        // Line level of bit idx within the frame for word w
        function automatic logic frame_bit(input logic [DB-1:0] w, input int idx);
            int ones;
            ones = 0;
            for (int i = 0; i < DB; i++) ones += int'(w[i]);
            if (idx == 0) return 1'b0;
            if (idx <= DB) return w[idx-1];
            if (PM != 0 && idx == DB + 1) return (PM == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
            return 1'b1;
        endfunction

        // Monitor: per-cycle check of {tx, ready, busy, done}
        initial begin : mon
            logic [DB-1:0] cur;
            int            cyc;
            logic          pend_done;
            logic          ignore;
            logic [3:0]    act_v;
            logic [3:0]    exp_v;
            cur = '0;
            cyc = 0;
            pend_done = 1'b0;
            ignore = 1'b0;
            forever begin
                @(negedge clk);
                act_v = {tx, ready, busy, done};
                if (rst_at_edge) begin
                    in_frame  = 1'b0;
                    pend_done = 1'b0;
                    ignore    = 1'b0;
                    check("reset_state", g, 0, 32'(act_v), 32'(4'b1100));
                end else if (in_frame && ignore) begin
                    if (!busy) in_frame = 1'b0;
                end else begin
                    if (!in_frame && (busy || !tx)) begin
                        check("frame_expected", g, 0, 32'(exp_q.size() > 0), 32'd1);
                        in_frame  = 1'b1;
                        pend_done = 1'b0;
                        cyc       = 0;
                        if (exp_q.size() > 0) cur = exp_q.pop_front();
                        else ignore = 1'b1;
                    end
                    if (in_frame && !ignore) begin
                        exp_v = {frame_bit(cur, cyc / C), 1'b0, 1'b1, 1'b0};
                        check("frame_line", g, cyc, 32'(act_v), 32'(exp_v));
                        cyc++;
                        if (cyc == L) begin
                            in_frame  = 1'b0;
                            pend_done = 1'b1;
                        end
                    end else if (!in_frame) begin
                        exp_v = {1'b1, 1'b1, 1'b0, pend_done};
                        check("idle_line", g, 0, 32'(act_v), 32'(exp_v));
                        pend_done = 1'b0;
                    end
                end
            end
        end

        // Offer w once ready is seen. With hold=1, valid stays high afterwards.
        // The task is called at a negedge and returns at a negedge.
        task automatic send(input logic [DB-1:0] w, input bit hold);
            int n;
            n = 0;
            while (!ready && n < 4 * L) begin
                @(negedge clk);
                n++;
            end
            check("ready_wait", g, n, 32'(ready), 32'd1);
            if (ready) begin
                data  = w;
                valid = 1'b1;
                exp_q.push_back(w);
                @(negedge clk);
                check("accept", g, 0, 32'({busy, tx}), 32'(2'b10));
                if (!hold) valid = 1'b0;
                data = DB'($urandom);
            end
        endtask

        task automatic idle_cycles(input int n);
            repeat (n) @(negedge clk);
        endtask

        // Driver: directed corner cases, then a randomized stream
        initial begin : drv
            int  n;
            bit  hold;
            logic [DB-1:0] w;
            rst = 1'b1;
            idle_cycles(3);
            rst = 1'b0;
            idle_cycles(2);

            // Reset in the middle of data bit 3 abandons the frame
            send(DB'(8'h55), 1'b0);
            idle_cycles(C * 4);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            idle_cycles(3);
            send(DB'(8'h55), 1'b0);
            idle_cycles(L + 2);

            // Parity patterns
            send(DB'(8'h07), 1'b0);
            idle_cycles(L + 2);
            send(DB'(8'h00), 1'b0);
            idle_cycles(L + 2);
            send(DB'(8'h1F), 1'b0);
            idle_cycles(L + 2);

            // Back-to-back with valid held high
            send(DB'(8'hA5), 1'b1);
            send(DB'(8'h3C), 1'b0);
            idle_cycles(L + 2);

            // Data change and valid pulse while busy are ignored
            send(DB'(8'h81), 1'b0);
            idle_cycles(8);
            data  = '1;
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            idle_cycles(L + 2);

            // Reset together with valid: no handshake
            rst   = 1'b1;
            valid = 1'b1;
            data  = DB'($urandom);
            @(negedge clk);
            rst   = 1'b0;
            valid = 1'b0;
            idle_cycles(4);

            // Randomized words, gaps and back-to-back runs
            for (int k = 0; k < 25; k++) begin
                w    = DB'($urandom);
                hold = (k != 24) && ($urandom_range(0, 2) == 0);
                send(w, hold);
                if (!hold) idle_cycles($urandom_range(0, 3));
            end

            n = 0;
            while ((exp_q.size() != 0 || in_frame) && n < 4 * L) begin
                @(negedge clk);
                n++;
            end
            idle_cycles(2);
            check("drain", g, n, 32'(exp_q.size()), 32'd0);
            fin_flag = 1'b1;
        end
    end

    initial begin : main
        int n;
        n = 0;
        while (!(g_cfg[0].fin_flag && g_cfg[1].fin_flag && g_cfg[2].fin_flag) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("finish", 0, n, 32'({g_cfg[0].fin_flag, g_cfg[1].fin_flag, g_cfg[2].fin_flag}), 32'(3'b111));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
